pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV64 pipeline. It watches the ID, EX and MEM stages and drives the write-enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It resolves three hazard classes:
- load-use hazards, with a 1-cycle bubble;
- taken branches resolved in MEM, by flushing the younger stages;
- multi-cycle data-memory accesses, using a ready handshake with a timeout watchdog.

## Interface
Parameters:
- MAX_WAIT, 16: maximum MEM_WAIT cycles before timeout; legal range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- id_rs1, id_rs2  in  5  source register indices of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- mem_branch, mem_zero  in  1  branch and zero flags from the EX/MEM register; taken = mem_branch & mem_zero.
- mem_mem_read, mem_mem_write  in  1  data-memory access in MEM.
- dmem_ready  in  1  data memory completes the current access this cycle.
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1  register load enables; 1 = advance.
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  load a bubble (control bits zeroed).
- pc_src  out  1  1 selects pc_plus_imm as the next PC.
- mem_err  out  1  1-cycle pulse on memory timeout.
- busy  out  1  FSM is not in RUN.
- stall_cycles  out  CNT_W  performance counter (see Configuration).
- flush_events  out  CNT_W  performance counter (see Configuration).

## Operation
FSM states: RUN, MEM_WAIT, TIMEOUT. Internal wait_cnt is 8 bits wide.

Defaults (outputs not named by an active condition):
- All write enables = 1.
- All flushes = 0.
- pc_src = 0, mem_err = 0.

Derived signals:
- acc = mem_mem_read | mem_mem_write.
- lu = ex_mem_read & ex_rd != 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).

RUN (conditions in priority order):
1. acc & !dmem_ready:
   - All write enables = 0; mem_wb_flush = 1.
   - Next state MEM_WAIT; wait_cnt <= 1.
2. Taken branch:
   - pc_src = 1; if_id_flush = 1, id_ex_flush = 1, ex_mem_flush = 1.
   - Stay in RUN.
3. lu:
   - pc_write = 0, if_id_write = 0, id_ex_flush = 1.
   - Stay in RUN. The hazard clears on the next cycle without extra state.
4. Otherwise: defaults apply.

MEM_WAIT:
- dmem_ready = 1:
  - Defaults apply, so the pipeline advances this cycle.
  - Next state RUN; wait_cnt <= 0.
  - Branch and load-use checks are not evaluated in this cycle; they resume in RUN.
- dmem_ready = 0 and wait_cnt == MAX_WAIT-1: same stall as RUN case 1; next state TIMEOUT.
- dmem_ready = 0 otherwise: same stall as RUN case 1; wait_cnt increments.

TIMEOUT (exactly one cycle):
- mem_err = 1; mem_wb_flush = 1 (the failed access never writes back).
- Other outputs at defaults, so the pipeline advances.
- Next state RUN; wait_cnt <= 0.

busy = (state != RUN).

Reset:
- While rst_n = 0 (combinational override): all write enables = 0, all flushes = 1, pc_src = 0, mem_err = 0.
- Clock edge with rst_n = 0: state <= RUN, wait_cnt <= 0, counters <= 0.
- Reset mid-MEM_WAIT or in TIMEOUT aborts the wait; no mem_err is issued.

## Timing
- All hazard outputs are combinational from the current state and inputs, and take effect at the next rising edge.
- Load-use costs exactly 1 bubble cycle.
- A taken branch costs 3 flushed instructions; the redirect is visible in the same cycle it is detected in MEM.
- A memory access with ready at wait cycle k stalls for k cycles; k = 0 means no stall.
- A timeout costs MAX_WAIT stall cycles, plus 1 TIMEOUT cycle in which the pipeline advances.
- Simultaneous events are resolved by priority: memory stall > branch > load-use. A pending load-use is re-evaluated after the stall ends.
- ex_rd = 0 never causes a stall.

## Configuration
Macro: HAZARD_PERF_CNT_EN.

Defined:
- stall_cycles increments on every cycle with pc_write = 0 and rst_n = 1.
- flush_events increments on every cycle with pc_src = 1.
- Both counters saturate at all-ones; neither wraps.

Undefined:
- Both outputs are tied to 0.
- No counter flops exist.

## Test plan
- Load-use: EX holds ld x5 (ex_rd=5, ex_mem_read=1), ID holds add x6,x5,x7 (id_rs1=5, id_uses_rs1=1) -> exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_flush=1; the next cycle is at defaults. Repeat with ex_rd=0 -> no stall.
- Branch: mem_branch=1, mem_zero=1 -> pc_src=1 and if_id/id_ex/ex_mem flush=1 for 1 cycle. Repeat with mem_zero=0 -> defaults.
- Memory wait: mem_mem_read=1 and dmem_ready held low for 3 cycles, then high -> 3 stall cycles with mem_wb_flush=1 and busy=1; on the ready cycle all enables=1 and the FSM returns to RUN.
- Timeout, MAX_WAIT=4: dmem_ready stays 0 -> 4 stall cycles, then 1 cycle with mem_err=1 and mem_wb_flush=1, then RUN.
- Priority: a memory stall, a taken branch and lu asserted together -> stall outputs only and pc_src=0. Sync reset asserted mid-MEM_WAIT -> state RUN, no mem_err.
- With HAZARD_PERF_CNT_EN defined: 1 load-use bubble + 3 wait cycles + 1 branch -> stall_cycles=4, flush_events=1. Both counters saturate at 0xFFFF with CNT_W=16.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-resolved branch flushes, multi-cycle dmem waits.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             pc_src,
    output logic             mem_err,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned WAIT_W    = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;

    logic acc, taken, lu;

    assign acc   = mem_mem_read | mem_mem_write;
    assign taken = mem_branch & mem_zero;
    assign lu    = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign busy = (state != RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state and hazard outputs; reset override applied last.
    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        pc_src       = 1'b0;
        mem_err      = 1'b0;

        case (state)
            RUN: begin
                if (acc && !dmem_ready) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_flush = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_nxt     = WAIT_ONE;
                end else if (taken) begin
                    pc_src       = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (lu) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_flush  = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_flush = 1'b1;
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = TIMEOUT;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_ONE;
                    end
                end
            end
            TIMEOUT: begin
                // Failed access is squashed while the pipeline moves on.
                mem_err      = 1'b1;
                mem_wb_flush = 1'b1;
                state_nxt    = RUN;
                wait_nxt     = '0;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mem_wb_flush = 1'b1;
            pc_src       = 1'b0;
            mem_err      = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating counters for stalled and redirected cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (pc_src && (flush_events != CNT_MAX)) begin
                flush_events <= flush_events + CNT_ONE;
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MAX_WAIT=4).
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic        mem_branch, mem_zero, mem_mem_read, mem_mem_write, dmem_ready;
    logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        pc_src, mem_err, busy;
    logic [15:0] stall_cycles, flush_events;
    logic        s_pc_write, s_if_id_write, s_id_ex_write, s_ex_mem_write;
    logic        s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush;
    logic        s_pc_src, s_mem_err, s_busy;
    logic [3:0]  s_stall_cycles, s_flush_events;

    int n_tests = 0;
    int n_fail  = 0;

    // Order: pc,if_id,id_ex,ex_mem writes | if_id,id_ex,ex_mem,mem_wb flushes | pc_src,mem_err,busy
    localparam logic [10:0] V_DEF    = 11'b1111_0000_000;
    localparam logic [10:0] V_DEF_B  = 11'b1111_0000_001;
    localparam logic [10:0] V_LU     = 11'b0011_0100_000;
    localparam logic [10:0] V_BR     = 11'b1111_1110_100;
    localparam logic [10:0] V_STALL  = 11'b0000_0001_000;
    localparam logic [10:0] V_STALLB = 11'b0000_0001_001;
    localparam logic [10:0] V_TMO    = 11'b1111_0001_011;
    localparam logic [10:0] V_RST    = 11'b0000_1111_000;
    localparam logic [10:0] V_RST_B  = 11'b0000_1111_001;

    logic [10:0] ov;
    assign ov = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                 pc_src, mem_err, busy};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .pc_src(pc_src),
        .mem_err(mem_err), .busy(busy), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .dmem_ready(dmem_ready),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_write(s_id_ex_write),
        .ex_mem_write(s_ex_mem_write), .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .ex_mem_flush(s_ex_mem_flush), .mem_wb_flush(s_mem_wb_flush), .pc_src(s_pc_src),
        .mem_err(s_mem_err), .busy(s_busy), .stall_cycles(s_stall_cycles),
        .flush_events(s_flush_events)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0;
        mem_branch = 1'b0; mem_zero = 1'b0;
        mem_mem_read = 1'b0; mem_mem_write = 1'b0; dmem_ready = 1'b0;
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] exp);
        #1;
        check(tag, 32'(ov), 32'(exp));
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        tick();
        chk("reset_outputs", V_RST);
        check("reset_stall_cnt", 32'(stall_cycles), 32'd0);
        check("reset_flush_cnt", 32'(flush_events), 32'd0);
        rst_n = 1'b1;
        chk("idle_defaults", V_DEF);
        tick();

        // Load-use: ld x5 in EX, add x6,x5,x7 in ID
        ex_rd = 5'd5; ex_mem_read = 1'b1; id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        chk("lu_bubble", V_LU);
        tick();
        ex_rd = 5'd0; ex_mem_read = 1'b0;
        chk("lu_next_defaults", V_DEF);
        tick();
        ex_rd = 5'd0; ex_mem_read = 1'b1; id_rs1 = 5'd0;
        chk("lu_rd_zero", V_DEF);
        tick();
        clear_inputs();

        // Branch taken then not taken
        mem_branch = 1'b1; mem_zero = 1'b1;
        chk("branch_taken", V_BR);
        tick();
        mem_zero = 1'b0;
        chk("branch_not_taken", V_DEF);
        tick();
        clear_inputs();

        // Memory wait: ready low for 3 cycles, then high
        mem_mem_read = 1'b1; dmem_ready = 1'b0;
        chk("mw_stall0", V_STALL);
        tick();
        chk("mw_stall1", V_STALLB);
        tick();
        chk("mw_stall2", V_STALLB);
        tick();
        dmem_ready = 1'b1;
        chk("mw_ready", V_DEF_B);
        tick();
        clear_inputs();
        chk("mw_back_run", V_DEF);

`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_cnt", 32'(stall_cycles), 32'd4);
        check("perf_flush_cnt", 32'(flush_events), 32'd1);
`else
        check("perf_stall_tied", 32'(stall_cycles), 32'd0);
        check("perf_flush_tied", 32'(flush_events), 32'd0);
`endif
        tick();

        // Load-use through rs2 only; rs1 match ignored when not used
        ex_rd = 5'd9; ex_mem_read = 1'b1; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
        chk("lu_rs2", V_LU);
        tick();
        id_rs2 = 5'd0; id_uses_rs2 = 1'b0; id_rs1 = 5'd9; id_uses_rs1 = 1'b0;
        chk("lu_rs1_unused", V_DEF);
        tick();
        clear_inputs();

        // Timeout with MAX_WAIT=4
        mem_mem_write = 1'b1; dmem_ready = 1'b0;
        chk("tmo_stall0", V_STALL);
        tick();
        chk("tmo_stall1", V_STALLB);
        tick();
        chk("tmo_stall2", V_STALLB);
        tick();
        chk("tmo_stall3", V_STALLB);
        tick();
        chk("tmo_err", V_TMO);
        tick();
        clear_inputs();
        chk("tmo_back_run", V_DEF);
        tick();

        // Priority: memory stall over branch over load-use
        mem_mem_read = 1'b1; dmem_ready = 1'b0; mem_branch = 1'b1; mem_zero = 1'b1;
        ex_rd = 5'd3; ex_mem_read = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        chk("prio_stall", V_STALL);
        tick();
        dmem_ready = 1'b1;
        chk("prio_ready_no_branch", V_DEF_B);
        tick();
        mem_mem_read = 1'b0;
        chk("prio_branch_over_lu", V_BR);
        tick();
        mem_branch = 1'b0;
        chk("prio_lu_resumes", V_LU);
        tick();
        clear_inputs();

        // Reset mid MEM_WAIT
        mem_mem_read = 1'b1; dmem_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        chk("rst_in_wait_comb", V_RST_B);
        tick();
        chk("rst_in_wait_after", V_RST);
        rst_n = 1'b1;
        clear_inputs();
        chk("rst_wait_run", V_DEF);
        tick();
        chk("rst_wait_no_err", V_DEF);

        // Saturation on the 4-bit-counter instance
        mem_branch = 1'b1; mem_zero = 1'b1;
        repeat (20) tick();
        clear_inputs();
        mem_mem_read = 1'b1; dmem_ready = 1'b0;
        repeat (40) tick();
        clear_inputs();
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check("sat_flush_cnt", 32'(s_flush_events), 32'd15);
        check("sat_stall_cnt", 32'(s_stall_cycles), 32'd15);
`else
        check("sat_flush_tied", 32'(s_flush_events), 32'd0);
        check("sat_stall_tied", 32'(s_stall_cycles), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
